// File: rtl/stage_sequence_ctrl.sv
// Stage sequencer for the multicycle RISC: decodes stage count, drives one-hot stage enables,
// LastStage/PC_Write back to the TimingGenerator, and counts retired instructions. Optional checker: STAGE_CHECK_EN.
module stage_sequence_ctrl #(
  parameter int              OP_W  = 6,
  parameter logic [OP_W-1:0] OP_LW = 6'h23,
  parameter logic [OP_W-1:0] OP_SW = 6'h2B,
  parameter logic [OP_W-1:0] OP_J  = 6'h02,
  parameter int              RET_W = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [2:0]       Cnt,
  input  logic [OP_W-1:0]  Opcode,
  output logic             LastStage,
  output logic [4:0]       StageEn,
  output logic             IR_Load,
  output logic             PC_Write,
  output logic [RET_W-1:0] RetireCnt,
  output logic             StageErr
);

  typedef enum logic [1:0] {CLS_J, CLS_R, CLS_SW, CLS_LW} cls_t;

  function automatic cls_t decode_class(input logic [OP_W-1:0] op);
    if (op == OP_LW)      return CLS_LW;
    else if (op == OP_SW) return CLS_SW;
    else if (op == OP_J)  return CLS_J;
    else                  return CLS_R;
  endfunction

  cls_t             r_class;
  cls_t             w_class;
  logic [2:0]       w_last_idx;
  logic [4:0]       w_stage_en;
  logic             w_last;
  logic             w_ir_load;
  logic [RET_W-1:0] r_retire;

  // During IF the class comes straight from the opcode; afterwards from the latched copy.
  always_comb begin
    w_class = (Cnt == 3'd0) ? decode_class(Opcode) : r_class;
    case (w_class)
      CLS_J:   w_last_idx = 3'd1;
      CLS_SW:  w_last_idx = 3'd3;
      CLS_LW:  w_last_idx = 3'd4;
      default: w_last_idx = 3'd2;
    endcase
  end

  always_comb begin
    w_stage_en = 5'b00000;
    w_last     = 1'b0;
    w_ir_load  = 1'b0;
    if (Rst) begin
      if (Cnt == 3'd0) begin
        w_stage_en = 5'b00001;
        w_ir_load  = 1'b1;
      end else if (Cnt <= w_last_idx) begin
        case (Cnt)
          3'd1:    w_stage_en = (w_class == CLS_J) ? 5'b00100 : 5'b00010;
          3'd2:    w_stage_en = 5'b00100;
          3'd3:    w_stage_en = 5'b01000;
          3'd4:    w_stage_en = 5'b10000;
          default: w_stage_en = 5'b00000;
        endcase
        w_last = (Cnt == w_last_idx);
      end
    end
  end

  assign StageEn   = w_stage_en;
  assign LastStage = w_last;
  assign PC_Write  = w_last;
  assign IR_Load   = w_ir_load;
  assign RetireCnt = r_retire;

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_class  <= CLS_R;
      r_retire <= '0;
    end else begin
      if (Cnt == 3'd0) r_class <= decode_class(Opcode);
      if (w_last)      r_retire <= r_retire + 1'b1;
    end
  end

`ifdef STAGE_CHECK_EN
  logic [2:0] r_prev_cnt;
  logic       r_prev_last;
  logic       r_started;
  logic       r_err;
  logic [3:0] w_exp_cnt;
  logic       w_chk_err;

  // Cnt must restart at 0 after reset or after a final stage, else advance by exactly one.
  always_comb begin
    w_exp_cnt = (!r_started || r_prev_last) ? 4'd0 : ({1'b0, r_prev_cnt} + 4'd1);
    w_chk_err = ({1'b0, Cnt} != w_exp_cnt) || (Cnt >= 3'd5);
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_prev_cnt  <= 3'd0;
      r_prev_last <= 1'b0;
      r_started   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prev_cnt  <= Cnt;
      r_prev_last <= w_last;
      r_started   <= 1'b1;
      if (w_chk_err) r_err <= 1'b1;
    end
  end

  assign StageErr = r_err;
`else
  assign StageErr = 1'b0;
`endif

endmodule
